hcms29xx_chain_ctrl: RTL and testbench
======================================

// Module: hcms29xx_chain_ctrl
// PURPOSE
//  Parametrised driver for a daisy-chain of HCMS-29xx dot-matrix LED units.
//  Runs the power-up sequence (reset pulse, dot-register clear, simultaneous-mode set).
//  Then accepts frames and control words over valid/ready handshakes and serialises them with a divided SCLK.
//  Sits between the display frame buffer and the board pins.
// PARAMETERS
//  N_UNITS   2   units in the chain (>=1)
//  UNIT_W    20  columns per unit
//  UNIT_H    8   bits per column (bit 7 unused by device)
//  CLK_DIV   4   clk cycles per SCLK half-period (>=1)
//  RST_CYC   64  clk cycles dev_rst_n held low after rst_n release
//  PWM_W     8   width of pwm_duty
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              async active-low reset
//  frame_data  in   N_UNITS*UNIT_W*UNIT_H  dot data; MSB shifted first
//  frame_valid in   1              frame offered
//  frame_ready out  1              frame accepted when valid&&ready
//  cw_data     in   8              control word; bit7 selects CW0/CW1
//  cw_valid    in   1              control word offered
//  cw_ready    out  1              control word accepted when valid&&ready
//  pwm_duty    in   PWM_W          blank duty (used only with macro)
//  busy        out  1              high whenever state != IDLE
//  dev_rst_n   out  1              device reset
//  dev_sclk    out  1              device serial clock, idle low
//  dev_din     out  1              device serial data
//  dev_rs      out  1              register select: 1=control, 0=dot
//  dev_ce_n    out  1              chip enable, latch on rising edge
//  dev_blank   out  1              display blank
// BEHAVIOUR
//  Clock/reset: clk; reset rst_n, asynchronous, active-low. Reset mid-operation aborts any shift immediately.
//  Reset values: dev_rst_n=0 dev_ce_n=1 dev_sclk=0 dev_din=0 dev_rs=0 dev_blank=1 frame_ready=0 cw_ready=0 busy=1.
//  States: RST -> CLR -> INITCW -> IDLE <-> {SHIFT_CW, SHIFT_DOT} -> LATCH -> IDLE.
//  RST: hold dev_rst_n=0 for RST_CYC clks, then dev_rst_n=1 and go to CLR.
//  CLR: shift N_UNITS*UNIT_W*UNIT_H zeros with rs=0, then LATCH (dots cleared).
//  INITCW: shift 8'h81 (CW1, serial-simultaneous) with rs=1, then LATCH. Later CWs reach all units.
//  SCLK: period 2*CLK_DIV clks. dev_din/dev_rs change only while sclk low; device samples on rising edge.
//  ce_n falls CLK_DIV clks before the first rising edge. It rises CLK_DIV clks after the last falling edge (LATCH).
//  LATCH then waits CLK_DIV clks with ce_n=1 before IDLE.
//  IDLE: dev_blank follows config; cw_ready=1; frame_ready=!cw_valid. CW has priority on simultaneous valid.
//  Accept: cw_data or frame_data captured into shift reg the same clk; ready deasserts the next clk.
//  Bit order: CW bit7 first; frame bit N*W*H-1 first (last unit's column UNIT_W-1, bit 7).
//  Counters: bit counter clog2(N*W*H+1) bits, exact terminal compare, no wrap.
//  Divider: counter resets at every state entry.
//  Latency: frame accept -> ce_n rise = CLK_DIV*(2*N*W*H+2)+1 clks. CW: replace N*W*H with 8.
//  A valid held during busy is not lost; it is accepted on return to IDLE.
// CONFIGURATION
//  HCMS_BLANK_PWM_EN defined: a free-running PWM_W counter drives dev_blank = (cnt >= pwm_duty) in IDLE/LATCH/SHIFT_*.
//    pwm_duty=0 -> always blank; dev_blank=1 in RST/CLR/INITCW.
//  Undefined: dev_blank=1 until first IDLE entry, then 0 permanently; pwm_duty ignored.
//    Brightness via CW0 only.
// STRUCTURE
//  hcms29xx_pkg: state enum, CW1_INIT=8'h81, CW_SEL_BIT=7, SSDM mux select codes.
//  Sub-module hcms_sclk_gen: CLK_DIV divider emitting sclk, rise_stb, fall_stb; restartable via clear input.
// TESTING
//  Reset release, N=2: dev_rst_n low 64 clks; 320 zero bits, rs=0; then 8'h81 with rs=1; busy falls.
//  cw_valid with 8'h4F in IDLE: cw_ready 1 clk; dev_din bits 0,1,0,0,1,1,1,1 on rises; rs=1; ce_n rises once.
//  Frame of alternating 0xAA bytes: 320 rises, first bit 1; ce_n rises after; frame_ready low while shifting.
//  cw_valid and frame_valid same clk: CW shifted first, then frame accepted on next IDLE; no data lost.
//  rst_n asserted mid-frame (bit 100): all outputs take reset values immediately; restart completes the full init sequence.
//  HCMS_BLANK_PWM_EN, PWM_W=8, pwm_duty=64: dev_blank low 64 of every 256 clks in IDLE.

Source files
------------

// File: rtl/hcms29xx_pkg.sv
// Shared types and constants for the HCMS-29xx daisy-chain driver.
package hcms29xx_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_CLR,
    ST_INITCW,
    ST_IDLE,
    ST_SHIFT_CW,
    ST_SHIFT_DOT,
    ST_LATCH
  } state_t;

  // Serial data mode select codes carried in bit 0 of control word 1.
  localparam logic SSDM_SERIAL       = 1'b0;
  localparam logic SSDM_SIMULTANEOUS = 1'b1;

  localparam int         CW_SEL_BIT = 7;
  localparam logic [7:0] CW1_INIT   = {1'b1, 6'b000000, SSDM_SIMULTANEOUS};

endpackage

// File: rtl/hcms_sclk_gen.sv
// Restartable SCLK divider: each half-period lasts CLK_DIV clks; sclk toggles only while run is high.
module hcms_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic sclk,
  output logic half_stb,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign half_stb = (cnt == LAST);
  assign rise_stb = half_stb && run && !sclk;
  assign fall_stb = half_stb && run && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= half_stb ? '0 : cnt + 1'b1;
      if (rise_stb || fall_stb) sclk <= !sclk;
    end
  end

endmodule

// File: rtl/hcms29xx_chain_ctrl.sv
// Power-up sequencer and frame/control-word serialiser for a chain of HCMS-29xx units.
// Define HCMS_BLANK_PWM_EN to drive dev_blank from a free-running PWM compare against pwm_duty.
module hcms29xx_chain_ctrl #(
  parameter int N_UNITS = 2,
  parameter int UNIT_W  = 20,
  parameter int UNIT_H  = 8,
  parameter int CLK_DIV = 4,
  parameter int RST_CYC = 64,
  parameter int PWM_W   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_UNITS*UNIT_W*UNIT_H-1:0]  frame_data,
  input  logic                              frame_valid,
  output logic                              frame_ready,
  input  logic [7:0]                        cw_data,
  input  logic                              cw_valid,
  output logic                              cw_ready,
  input  logic [PWM_W-1:0]                  pwm_duty,
  output logic                              busy,
  output logic                              dev_rst_n,
  output logic                              dev_sclk,
  output logic                              dev_din,
  output logic                              dev_rs,
  output logic                              dev_ce_n,
  output logic                              dev_blank
);

  import hcms29xx_pkg::*;

  localparam int NB   = N_UNITS * UNIT_W * UNIT_H;
  localparam int BC_W = $clog2(NB + 1);
  localparam int RC_W = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;
  localparam logic [BC_W-1:0] BITS_DOT = BC_W'(NB);
  localparam logic [BC_W-1:0] BITS_CW  = BC_W'(8);
  localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYC - 1);

  state_t          state, state_nxt, latch_ret;
  logic [NB-1:0]   sreg;
  logic [BC_W-1:0] bcnt;
  logic [BC_W-1:0] bits_tgt;
  logic [RC_W-1:0] rcnt;
  logic            half;
  logic            shifting, run, div_clear, ce_n_int;
  logic            sclk_int, half_stb, rise_stb, fall_stb;
  logic            cw_take, frame_take;

  assign shifting   = state inside {ST_CLR, ST_INITCW, ST_SHIFT_CW, ST_SHIFT_DOT};
  assign run        = shifting && half;
  assign div_clear  = (state_nxt != state);
  assign cw_take    = (state == ST_IDLE) && cw_valid;
  assign frame_take = (state == ST_IDLE) && frame_valid && !cw_valid;
  assign bits_tgt   = (state == ST_INITCW || state == ST_SHIFT_CW) ? BITS_CW : BITS_DOT;

  assign busy        = (state != ST_IDLE);
  assign cw_ready    = (state == ST_IDLE);
  assign frame_ready = (state == ST_IDLE) && !cw_valid;

  hcms_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (div_clear),
    .run      (run),
    .sclk     (sclk_int),
    .half_stb (half_stb),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RST:       if (rcnt == RST_LAST) state_nxt = ST_CLR;
      ST_CLR, ST_INITCW, ST_SHIFT_CW, ST_SHIFT_DOT:
                    if (fall_stb && bcnt == bits_tgt) state_nxt = ST_LATCH;
      ST_LATCH:     if (half && half_stb) state_nxt = latch_ret;
      ST_IDLE: begin
        if (cw_take)         state_nxt = ST_SHIFT_CW;
        else if (frame_take) state_nxt = ST_SHIFT_DOT;
      end
      default:      state_nxt = ST_RST;
    endcase
  end

  // Shift states spend their first half-period with ce_n high; LATCH spends its second one that way.
  always_comb begin
    ce_n_int = 1'b1;
    if (shifting)                ce_n_int = !half;
    else if (state == ST_LATCH)  ce_n_int = half;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RST;
      latch_ret <= ST_INITCW;
      sreg      <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      half      <= 1'b0;
      dev_rs    <= 1'b0;
      dev_rst_n <= 1'b0;
    end else begin
      state     <= state_nxt;
      dev_rst_n <= (state_nxt != ST_RST);
      half      <= div_clear ? 1'b0 : (half | half_stb);
      rcnt      <= (state == ST_RST) ? rcnt + 1'b1 : '0;
      if (div_clear)     bcnt <= '0;
      else if (rise_stb) bcnt <= bcnt + 1'b1;
      if (fall_stb) sreg <= {sreg[NB-2:0], 1'b0};
      if (div_clear) begin
        case (state_nxt)
          ST_CLR: begin
            sreg      <= '0;
            dev_rs    <= 1'b0;
            latch_ret <= ST_INITCW;
          end
          ST_INITCW: begin
            sreg      <= {CW1_INIT, {(NB-8){1'b0}}};
            dev_rs    <= 1'b1;
            latch_ret <= ST_IDLE;
          end
          ST_SHIFT_CW: begin
            sreg      <= {cw_data, {(NB-8){1'b0}}};
            dev_rs    <= 1'b1;
            latch_ret <= ST_IDLE;
          end
          ST_SHIFT_DOT: begin
            sreg      <= frame_data;
            dev_rs    <= 1'b0;
            latch_ret <= ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Pin-side registers keep sclk, din and ce_n aligned so data only moves with sclk low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dev_sclk <= 1'b0;
      dev_din  <= 1'b0;
      dev_ce_n <= 1'b1;
    end else begin
      dev_sclk <= sclk_int;
      dev_din  <= shifting ? sreg[NB-1] : 1'b0;
      dev_ce_n <= ce_n_int;
    end
  end

`ifdef HCMS_BLANK_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      dev_blank <= 1'b1;
    end else begin
      pwm_cnt   <= pwm_cnt + 1'b1;
      dev_blank <= (state inside {ST_RST, ST_CLR, ST_INITCW}) ? 1'b1 : (pwm_cnt >= pwm_duty);
    end
  end
`else
  logic pwm_unused;
  assign pwm_unused = ^pwm_duty;

  // Without PWM the display stays blanked until init completes, then brightness is set by CW0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      dev_blank <= 1'b1;
    else if (state_nxt == ST_IDLE)   dev_blank <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_hcms29xx_chain_ctrl.sv
// Self-checking bench for hcms29xx_chain_ctrl: captures serial traffic and compares against the shifted data.
module tb_hcms29xx_chain_ctrl;
  import hcms29xx_pkg::*;

  localparam int N_UNITS = 2;
  localparam int UNIT_W  = 20;
  localparam int UNIT_H  = 8;
  localparam int CLK_DIV = 4;
  localparam int RST_CYC = 64;
  localparam int PWM_W   = 8;
  localparam int NB      = N_UNITS * UNIT_W * UNIT_H;
  localparam int BOUND   = 4 * CLK_DIV * (NB + 16);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NB-1:0]    frame_data;
  logic             frame_valid;
  logic             frame_ready;
  logic [7:0]       cw_data;
  logic             cw_valid;
  logic             cw_ready;
  logic [PWM_W-1:0] pwm_duty;
  logic             busy, dev_rst_n, dev_sclk, dev_din, dev_rs, dev_ce_n, dev_blank;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   ce_rises = 0;
  int   proto_err = 0;
  logic bits_q[$];
  logic rs_q[$];
  logic prev_sclk = 1'b0;
  logic prev_din = 1'b0;
  logic prev_ce_n = 1'b1;

  always #5 clk = ~clk;

  hcms29xx_chain_ctrl #(
    .N_UNITS(N_UNITS), .UNIT_W(UNIT_W), .UNIT_H(UNIT_H),
    .CLK_DIV(CLK_DIV), .RST_CYC(RST_CYC), .PWM_W(PWM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .cw_data(cw_data), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .pwm_duty(pwm_duty), .busy(busy),
    .dev_rst_n(dev_rst_n), .dev_sclk(dev_sclk), .dev_din(dev_din),
    .dev_rs(dev_rs), .dev_ce_n(dev_ce_n), .dev_blank(dev_blank)
  );

  // Pin monitor: records din/rs on every sclk rise and flags protocol violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk = 1'b0;
      prev_ce_n = 1'b1;
    end else begin
      if (dev_sclk && !prev_sclk) begin
        bits_q.push_back(dev_din);
        rs_q.push_back(dev_rs);
        if (dev_ce_n) proto_err++;
      end
      if (dev_sclk && prev_sclk && dev_din !== prev_din) proto_err++;
      if (dev_ce_n && !prev_ce_n) ce_rises++;
      prev_sclk = dev_sclk;
      prev_din  = dev_din;
      prev_ce_n = dev_ce_n;
    end
  end

  task automatic check_output(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] pack_bits(input int start, input int len);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < len; i++)
      v = {v[NB-2:0], (start + i < bits_q.size()) ? bits_q[start + i] : 1'bx};
    return v;
  endfunction

  function automatic int rs_bad(input int start, input int len, input logic exp);
    int e;
    e = 0;
    for (int i = 0; i < len; i++)
      if (start + i >= rs_q.size() || rs_q[start + i] !== exp) e++;
    return e;
  endfunction

  function automatic logic [NB-1:0] rand_frame();
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic clear_capture();
    bits_q.delete();
    rs_q.delete();
    ce_rises = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_dev_rst_n"},   dev_rst_n,   1'b0);
    check_output({tag, "_dev_ce_n"},    dev_ce_n,    1'b1);
    check_output({tag, "_dev_sclk"},    dev_sclk,    1'b0);
    check_output({tag, "_dev_din"},     dev_din,     1'b0);
    check_output({tag, "_dev_rs"},      dev_rs,      1'b0);
    check_output({tag, "_dev_blank"},   dev_blank,   1'b1);
    check_output({tag, "_frame_ready"}, frame_ready, 1'b0);
    check_output({tag, "_cw_ready"},    cw_ready,    1'b0);
    check_output({tag, "_busy"},        busy,        1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 2 * BOUND) begin
      @(posedge clk); #1;
      guard++;
    end
    check_output({tag, "_reach_idle"}, busy, 1'b0);
  endtask

  task automatic check_init(input string tag);
    int n;
    clear_capture();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < RST_CYC + 8) begin
      @(posedge clk); #1;
      n++;
      if (dev_rst_n) break;
    end
    check_count({tag, "_rst_low_clks"}, n, RST_CYC);
    wait_idle(tag);
    check_count({tag, "_bit_count"}, bits_q.size(), NB + 8);
    check_vec({tag, "_clear_bits"}, pack_bits(0, NB), '0);
    check_vec({tag, "_cw1_bits"}, pack_bits(NB, 8), NB'(8'h81));
    check_count({tag, "_rs_errors"}, rs_bad(0, NB, 1'b0) + rs_bad(NB, 8, 1'b1), 0);
    check_count({tag, "_ce_rises"}, ce_rises, 2);
`ifndef HCMS_BLANK_PWM_EN
    check_output({tag, "_blank_after_init"}, dev_blank, 1'b0);
`endif
  endtask

  task automatic apply_stimulus(input bit is_cw, input logic [NB-1:0] data, output int lat);
    int  guard;
    int  ready_bad;
    bit  seen_low;
    @(negedge clk);
    if (is_cw) begin
      cw_data  = data[7:0];
      cw_valid = 1'b1;
    end else begin
      frame_data  = data;
      frame_valid = 1'b1;
    end
    guard = 0;
    while (!(is_cw ? cw_ready : frame_ready) && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check_count(is_cw ? "cw_accept_in_time" : "frame_accept_in_time", (guard < BOUND) ? 1 : 0, 1);
    @(posedge clk); #1;
    cw_valid    = 1'b0;
    frame_valid = 1'b0;
    check_output(is_cw ? "cw_ready_drop" : "frame_ready_drop", is_cw ? cw_ready : frame_ready, 1'b0);
    lat = 0;
    seen_low = 1'b0;
    ready_bad = 0;
    while (lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
      if (frame_ready || cw_ready) ready_bad++;
      if (!dev_ce_n) seen_low = 1'b1;
      else if (seen_low) break;
    end
    check_count(is_cw ? "cw_ready_low_while_busy" : "frame_ready_low_while_busy", ready_bad, 0);
  endtask

  task automatic run_xfer(input string tag, input bit is_cw, input logic [NB-1:0] data);
    int            lat;
    int            nb;
    logic [NB-1:0] exp_v;
    nb    = is_cw ? 8 : NB;
    exp_v = is_cw ? NB'(data[7:0]) : data;
    clear_capture();
    apply_stimulus(is_cw, data, lat);
    wait_idle(tag);
    check_count({tag, "_latency"}, lat, CLK_DIV * (2 * nb + 2) + 1);
    check_count({tag, "_bit_count"}, bits_q.size(), nb);
    check_vec({tag, "_bits"}, pack_bits(0, nb), exp_v);
    check_count({tag, "_rs_errors"}, rs_bad(0, nb, is_cw), 0);
    check_count({tag, "_ce_rises"}, ce_rises, 1);
  endtask

  initial begin
    logic [NB-1:0] fr;
    logic [7:0]    cw;
    int            guard;
    int            blank_low;

    frame_data  = '0;
    frame_valid = 1'b0;
    cw_data     = '0;
    cw_valid    = 1'b0;
    pwm_duty    = PWM_W'(64);
    rst_n       = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(negedge clk);
    check_reset_values("por_hold");

    check_init("init");

    run_xfer("cw_4f", 1'b1, NB'(8'h4F));

    run_xfer("frame_aa", 1'b0, {(NB/8){8'hAA}});
    check_output("frame_aa_first_bit", (bits_q.size() > 0) ? bits_q[0] : 1'bx, 1'b1);

    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) begin
        run_xfer("rand_frame", 1'b0, rand_frame());
      end else begin
        cw = 8'($urandom);
        cw[CW_SEL_BIT] = (t == 1) ? 1'b0 : 1'b1;
        run_xfer("rand_cw", 1'b1, NB'(cw));
      end
    end

    // Simultaneous offers: the control word goes first and the frame waits for the next IDLE.
    clear_capture();
    cw = 8'($urandom);
    fr = rand_frame();
    @(negedge clk);
    cw_data     = cw;
    frame_data  = fr;
    cw_valid    = 1'b1;
    frame_valid = 1'b1;
    #1;
    check_output("simul_cw_ready", cw_ready, 1'b1);
    check_output("simul_frame_ready_blocked", frame_ready, 1'b0);
    @(posedge clk); #1;
    cw_valid = 1'b0;
    guard = 0;
    while (!frame_ready && guard < BOUND) begin
      @(negedge clk);
      guard++;
    end
    check_count("simul_frame_accept_in_time", (guard < BOUND) ? 1 : 0, 1);
    @(posedge clk); #1;
    frame_valid = 1'b0;
    wait_idle("simul");
    check_count("simul_bit_count", bits_q.size(), NB + 8);
    check_vec("simul_cw_bits", pack_bits(0, 8), NB'(cw));
    check_vec("simul_frame_bits", pack_bits(8, NB), fr);
    check_count("simul_rs_errors", rs_bad(0, 8, 1'b1) + rs_bad(8, NB, 1'b0), 0);
    check_count("simul_ce_rises", ce_rises, 2);

`ifdef HCMS_BLANK_PWM_EN
    blank_low = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (!dev_blank) blank_low++;
    end
    check_count("pwm_blank_low_per_256", blank_low, 64);
`else
    blank_low = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      if (!dev_blank) blank_low++;
    end
    check_count("idle_blank_low_per_256", blank_low, 256);
`endif

    // Reset in the middle of a frame must abort immediately and rerun the whole power-up sequence.
    clear_capture();
    @(negedge clk);
    frame_data  = rand_frame();
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    guard = 0;
    while (bits_q.size() < 100 && guard < BOUND) begin
      @(posedge clk); #1;
      guard++;
    end
    check_count("midreset_reached_bit100", bits_q.size(), 100);
    check_output("midreset_ce_active", dev_ce_n, 1'b0);
    rst_n = 1'b0;
    #1 check_reset_values("midreset");
    #20;
    check_init("reinit");

    run_xfer("post_reinit_frame", 1'b0, rand_frame());

    check_count("protocol_errors", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
